// File: rtl/branch_pkg.sv
// Shared constants and types for the branch predictor: opcodes, the two-bit
// counter encoding, and the saturating counter step.
package branch_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned CNT_W = 2;

    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [CNT_W-1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_t;

    localparam cnt_t CNT_RESET = CNT_WNT;

    // Saturating step toward the resolved direction.
    function automatic cnt_t cnt_next(input cnt_t c, input logic taken);
        cnt_t r;
        r = c;
        if (taken) begin
            if (c != CNT_ST) r = cnt_t'(CNT_W'(c + 2'd1));
        end else begin
            if (c != CNT_SNT) r = cnt_t'(CNT_W'(c - 2'd1));
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side and resolve-side signals of the branch predictor; the fetch/EX
// logic is the master, the predictor the slave.
interface branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    logic [31:0]     Inst;
    logic [XLEN-1:0] PC;
    logic            Valid;
    logic            Stall;
    logic            Flush;
    logic            Upd_Valid;
    logic [XLEN-1:0] Upd_PC;
    logic            Upd_Taken;
    logic            Br_Dectected;
    logic            Pred_Taken;
    logic [XLEN-1:0] Pred_Target;
    logic            Jalr_Dec;

    modport master (
        output Inst, PC, Valid, Stall, Flush, Upd_Valid, Upd_PC, Upd_Taken,
        input  Br_Dectected, Pred_Taken, Pred_Target, Jalr_Dec
    );

    modport slave (
        input  Inst, PC, Valid, Stall, Flush, Upd_Valid, Upd_PC, Upd_Taken,
        output Br_Dectected, Pred_Taken, Pred_Target, Jalr_Dec
    );
endinterface

// File: rtl/branch_decode.sv
// Combinational control-transfer decode and PC-relative target generation.
module branch_decode
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            valid,
    output logic            is_b_c,
    output logic            is_jal_c,
    output logic            is_jalr_c,
    output logic [XLEN-1:0] target_c
);

    logic [OPC_W-1:0]   opcode_c;
    logic signed [12:0] imm_b_c;
    logic signed [20:0] imm_j_c;

    always_comb begin
        opcode_c  = inst[OPC_W-1:0];
        imm_b_c   = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_j_c   = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        is_b_c    = valid && (opcode_c == OPC_BRANCH);
        is_jal_c  = valid && (opcode_c == OPC_JAL);
        is_jalr_c = valid && (opcode_c == OPC_JALR);
        target_c  = '0;
        // Signed casts sign-extend the immediates; the sum wraps modulo 2^XLEN.
        if (is_b_c) begin
            target_c = pc + XLEN'(imm_b_c);
        end else if (is_jal_c) begin
            target_c = pc + XLEN'(imm_j_c);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal two-bit-counter branch predictor with registered prediction outputs.
// Define BP_GSHARE_EN to XOR the table index with a global history register.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = 6
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bus
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    cnt_t             bht [ENTRIES];
    logic [IDX_W-1:0] look_idx_c;
    logic [IDX_W-1:0] upd_idx_c;

    logic             is_b_c;
    logic             is_jal_c;
    logic             is_jalr_c;
    logic [XLEN-1:0]  target_c;
    logic             pred_taken_c;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    assign look_idx_c = bus.PC[IDX_W+1:2] ^ ghr;
    assign upd_idx_c  = bus.Upd_PC[IDX_W+1:2] ^ ghr;

    // History shifts in resolved directions, frozen while the front end stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (bus.Upd_Valid && !bus.Stall) begin
            ghr <= IDX_W'({ghr, bus.Upd_Taken});
        end
    end
`else
    assign look_idx_c = bus.PC[IDX_W+1:2];
    assign upd_idx_c  = bus.Upd_PC[IDX_W+1:2];
`endif

    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^{bus.Upd_PC[XLEN-1:IDX_W+2], bus.Upd_PC[1:0]};

    branch_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst      (bus.Inst),
        .pc        (bus.PC),
        .valid     (bus.Valid),
        .is_b_c    (is_b_c),
        .is_jal_c  (is_jal_c),
        .is_jalr_c (is_jalr_c),
        .target_c  (target_c)
    );

    // Lookup reads the table before this edge's update lands (no bypass).
    always_comb begin
        pred_taken_c = is_jal_c || is_jalr_c;
        if (is_b_c) begin
            pred_taken_c = bht[look_idx_c][1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht[i] <= CNT_RESET;
            end
        end else if (bus.Upd_Valid) begin
            bht[upd_idx_c] <= cnt_next(bht[upd_idx_c], bus.Upd_Taken);
        end
    end

    // Flush outranks Stall; Stall freezes the whole prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Br_Dectected <= 1'b0;
            bus.Pred_Taken   <= 1'b0;
            bus.Jalr_Dec     <= 1'b0;
            bus.Pred_Target  <= '0;
        end else if (bus.Flush) begin
            bus.Br_Dectected <= 1'b0;
            bus.Pred_Taken   <= 1'b0;
            bus.Jalr_Dec     <= 1'b0;
            bus.Pred_Target  <= '0;
        end else if (!bus.Stall) begin
            bus.Br_Dectected <= is_b_c || is_jal_c || is_jalr_c;
            bus.Pred_Taken   <= pred_taken_c;
            bus.Jalr_Dec     <= is_jalr_c;
            bus.Pred_Target  <= target_c;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed cases plus randomized
// traffic against a table-of-integers reference model.
module tb_branch_predictor;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned ENTRIES = 64;

    localparam logic [31:0] I_BEQ  = 32'h00728463;
    localparam logic [31:0] I_JAL  = 32'hff5ff0ef;
    localparam logic [31:0] I_BGEU = 32'hfe52fee3;
    localparam logic [31:0] I_JALR = 32'hf9c382e7;
    localparam logic [31:0] I_ADD  = 32'h005282b3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN)) bus ();

    branch_predictor #(
        .XLEN  (XLEN),
        .IDX_W (IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int          model_cnt [ENTRIES];
    logic        exp_br, exp_taken, exp_jalr;
    logic [31:0] exp_tgt;

    function automatic logic [31:0] b_off(input logic [31:0] i);
        int v;
        v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        return 32'(v);
    endfunction

    function automatic logic [31:0] j_off(input logic [31:0] i);
        int v;
        v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
            + int'(i[30:21]) * 2;
        return 32'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) model_cnt[i] = 1;
        {exp_br, exp_taken, exp_jalr, exp_tgt} = '0;
    endtask

    // Reference behaviour at one rising edge: predict from old counters, then train.
    task automatic model_edge();
        int idx, u;
        logic [6:0] op;
        if (bus.Flush) begin
            {exp_br, exp_taken, exp_jalr, exp_tgt} = '0;
        end else if (!bus.Stall) begin
            {exp_br, exp_taken, exp_jalr, exp_tgt} = '0;
            idx = int'((bus.PC / 4) % ENTRIES);
            op  = bus.Inst[6:0];
            if (bus.Valid) begin
                if (op == 7'h63) begin
                    exp_br = 1'b1; exp_taken = (model_cnt[idx] >= 2);
                    exp_tgt = bus.PC + b_off(bus.Inst);
                end else if (op == 7'h6F) begin
                    exp_br = 1'b1; exp_taken = 1'b1;
                    exp_tgt = bus.PC + j_off(bus.Inst);
                end else if (op == 7'h67) begin
                    exp_br = 1'b1; exp_taken = 1'b1; exp_jalr = 1'b1;
                end
            end
        end
        if (bus.Upd_Valid) begin
            u = int'((bus.Upd_PC / 4) % ENTRIES);
            if (bus.Upd_Taken && model_cnt[u] < 3) model_cnt[u]++;
            else if (!bus.Upd_Taken && model_cnt[u] > 0) model_cnt[u]--;
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic valid,
                         input logic stall, input logic flush, input logic uv,
                         input logic [31:0] upc, input logic ut);
        bus.Inst = inst; bus.PC = pc; bus.Valid = valid; bus.Stall = stall;
        bus.Flush = flush; bus.Upd_Valid = uv; bus.Upd_PC = upc; bus.Upd_Taken = ut;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        drive('0, '0, 0, 0, 0, 0, '0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(I_BEQ, 32'h100, 1, 0, 0, 1, 32'h100, 1);
        model_reset();
        @(posedge clk); #1;
        checks++;
        if ({bus.Br_Dectected, bus.Pred_Taken, bus.Jalr_Dec, bus.Pred_Target} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got %0b%0b%0b %h want all zero", bus.Br_Dectected,
                     bus.Pred_Taken, bus.Jalr_Dec, bus.Pred_Target);
        end
        drive('0, '0, 0, 0, 0, 0, '0, 0);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.Br_Dectected !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle br got %b want 0", bus.Br_Dectected);
        end
    endtask

    task automatic test_directed();
        logic [31:0] insts [6] = '{I_BEQ, I_JAL, I_BGEU, I_JALR, I_ADD, I_BEQ};
        logic [31:0] pcs   [6] = '{32'h100, 32'h20, 32'h40, 32'h80, 32'h84, 32'h100};
        logic        vals  [6] = '{1, 1, 1, 1, 1, 0};
        logic [34:0] want  [6] = '{{3'b100, 32'h108}, {3'b110, 32'h14}, {3'b100, 32'h3C},
                                   {3'b111, 32'h0}, 35'd0, 35'd0};
        logic [34:0] got;
        for (int k = 0; k < 6; k++) begin
            drive(insts[k], pcs[k], vals[k], 0, 0, 0, '0, 0);
            tick();
            got = {bus.Br_Dectected, bus.Pred_Taken, bus.Jalr_Dec, bus.Pred_Target};
            checks++;
            if (got !== want[k]) begin
                errors++;
                $display("FAIL directed_%0d got %h want %h", k, got, want[k]);
            end
            checks++;
            if (got !== {exp_br, exp_taken, exp_jalr, exp_tgt}) begin
                errors++;
                $display("FAIL directed_model_%0d got %h want %h", k, got,
                         {exp_br, exp_taken, exp_jalr, exp_tgt});
            end
        end
    endtask

    task automatic test_counter();
        // Each step: n updates of direction d at 0x100, then probe the beq there.
        int   n_upd [4] = '{2, 5, 1, 1};
        logic d_upd [4] = '{1, 0, 1, 1};
        logic want  [4] = '{1, 0, 0, 1};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < n_upd[s]; k++) begin
                drive(I_ADD, 32'h0, 0, 0, 0, 1, 32'h100, d_upd[s]);
                tick();
            end
            drive(I_BEQ, 32'h100, 1, 0, 0, 0, '0, 0);
            tick();
            checks++;
            if (bus.Pred_Taken !== want[s] || bus.Pred_Taken !== exp_taken) begin
                errors++;
                $display("FAIL counter_step_%0d taken got %b want %b", s, bus.Pred_Taken, want[s]);
            end
        end
        // Alias: 0x100 + 64*4 maps to the same counter, now weak-taken.
        drive(I_BEQ, 32'h200, 1, 0, 0, 0, '0, 0);
        tick();
        checks++;
        if (bus.Pred_Taken !== 1'b1 || bus.Pred_Target !== 32'h208) begin
            errors++;
            $display("FAIL alias got %b %h want 1 00000208", bus.Pred_Taken, bus.Pred_Target);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(I_BEQ, 32'h100, 1, 0, 0, 1, 32'h100, 1);
        tick();
        checks++;
        if (bus.Pred_Taken !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_old got %b want 0", bus.Pred_Taken);
        end
        drive(I_BEQ, 32'h100, 1, 0, 0, 0, '0, 0);
        tick();
        checks++;
        if (bus.Pred_Taken !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_after got %b want 1", bus.Pred_Taken);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] chg [3] = '{I_JAL, I_JALR, I_ADD};
        logic [34:0] got;
        do_reset();
        drive(I_BEQ, 32'h100, 1, 0, 0, 0, '0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(chg[k], 32'h40 + 32'(k * 4), 1, 1, 0, 0, '0, 0);
            tick();
            got = {bus.Br_Dectected, bus.Pred_Taken, bus.Jalr_Dec, bus.Pred_Target};
            checks++;
            if (got !== {3'b100, 32'h108} || got !== {exp_br, exp_taken, exp_jalr, exp_tgt}) begin
                errors++;
                $display("FAIL stall_hold_%0d got %h want %h", k, got, {3'b100, 32'h108});
            end
        end
        drive(I_JAL, 32'h20, 1, 1, 1, 0, '0, 0);
        tick();
        got = {bus.Br_Dectected, bus.Pred_Taken, bus.Jalr_Dec, bus.Pred_Target};
        checks++;
        if (got !== 35'd0) begin
            errors++;
            $display("FAIL flush_over_stall got %h want 0", got);
        end
        drive(I_JAL, 32'h20, 1, 0, 0, 0, '0, 0);
        tick();
        checks++;
        if (bus.Pred_Target !== 32'h14 || bus.Pred_Taken !== 1'b1) begin
            errors++;
            $display("FAIL after_flush got %b %h want 1 00000014", bus.Pred_Taken, bus.Pred_Target);
        end
    endtask

    task automatic test_reset_midop();
        for (int k = 0; k < 2; k++) begin
            drive(I_ADD, 32'h0, 0, 0, 0, 1, 32'h100, 1);
            tick();
        end
        drive(I_BEQ, 32'h100, 1, 0, 0, 0, '0, 0);
        tick();
        checks++;
        if (bus.Pred_Taken !== 1'b1) begin
            errors++;
            $display("FAIL midop_trained got %b want 1", bus.Pred_Taken);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.Br_Dectected, bus.Pred_Taken, bus.Pred_Target} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset got %b%b %h want zero", bus.Br_Dectected,
                     bus.Pred_Taken, bus.Pred_Target);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(I_BEQ, 32'h100, 0, 0, 0, 0, '0, 0);
        tick();
        checks++;
        if (bus.Br_Dectected !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_invalid got %b want 0", bus.Br_Dectected);
        end
        drive(I_BEQ, 32'h100, 1, 0, 0, 0, '0, 0);
        tick();
        checks++;
        if ({bus.Br_Dectected, bus.Pred_Taken, bus.Pred_Target} !== {2'b10, 32'h108}) begin
            errors++;
            $display("FAIL post_reset_first got %b%b %h want 10 00000108", bus.Br_Dectected,
                     bus.Pred_Taken, bus.Pred_Target);
        end
    endtask

    task automatic test_random();
        logic [31:0] inst, pc, upc;
        logic [34:0] got;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            inst = $urandom;
            case ($urandom_range(0, 4))
                0, 1: inst[6:0] = 7'h63;
                2:    inst[6:0] = 7'h6F;
                3:    inst[6:0] = 7'h67;
                default: ;
            endcase
            pc  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) * 4);
            upc = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) * 4);
            drive(inst, pc, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 1) == 1, upc,
                  $urandom_range(0, 99) < 60);
            tick();
            got = {bus.Br_Dectected, bus.Pred_Taken, bus.Jalr_Dec, bus.Pred_Target};
            checks++;
            if (got !== {exp_br, exp_taken, exp_jalr, exp_tgt}) begin
                errors++;
                $display("FAIL random_%0d got %h want %h", n, got,
                         {exp_br, exp_taken, exp_jalr, exp_tgt});
            end
        end
    endtask

    initial begin
        drive('0, '0, 0, 0, 0, 0, '0, 0);
        model_reset();
        test_reset();
        test_directed();
        test_counter();
        test_same_cycle();
        test_stall_flush();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/instruction/target width.
REQ-002 SHALL have parameter IDX_W, default 6, meaning log2 of BHT entries (2^IDX_W two-bit counters).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Inst  input  32  fetched instruction.
REQ-006 SHALL have port PC  input  XLEN  address of Inst.
REQ-007 SHALL have port Valid  input  1  Inst/PC qualify this cycle.
REQ-008 SHALL have port Stall  input  1  hold all outputs and the history register.
REQ-009 SHALL have port Flush  input  1  kill the prediction being registered.
REQ-010 SHALL have port Upd_Valid  input  1  resolved-branch update from EX.
REQ-011 SHALL have port Upd_PC  input  XLEN  PC of resolved branch.
REQ-012 SHALL have port Upd_Taken  input  1  resolved direction.
REQ-013 SHALL have port Br_Dectected  output  1  registered: Inst was B-type, JAL or JALR.
REQ-014 SHALL have port Pred_Taken  output  1  registered predicted direction.
REQ-015 SHALL have port Pred_Target  output  XLEN  registered PC+imm target.
REQ-016 SHALL have port Jalr_Dec  output  1  registered: Inst was JALR (target not computable).

Function
REQ-017 Decode SHALL use opcode 1100011 (B), 1101111 (JAL), 1100111 (JALR); any other opcode or Valid=0 gives Br_Dectected=0.
REQ-018 Outputs SHALL update on the rising clk edge after Inst/PC are presented (1-cycle latency), when Stall=0.
REQ-019 B-type: Pred_Taken SHALL equal bit 1 of counter at index PC[IDX_W+1:2]; Pred_Target = PC + sign-extended B-immediate, modulo 2^XLEN.
REQ-020 JAL: Pred_Taken=1; Pred_Target = PC + sign-extended J-immediate.
REQ-021 JALR: Pred_Taken=1, Jalr_Dec=1, Pred_Target=0.
REQ-022 Non-branch: Pred_Taken=0, Jalr_Dec=0, Pred_Target=0.
REQ-023 Stall=1 SHALL hold all outputs; Flush=1 (Stall=0) SHALL register all outputs as 0; Flush has priority over Stall.
REQ-024 Upd_Valid=1 SHALL update counter at Upd_PC[IDX_W+1:2] on the edge: taken increments saturating at 11, not-taken decrements saturating at 00; updates proceed regardless of Stall/Flush.
REQ-025 Counter encoding SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-026 Lookup and update to the same index in the same cycle SHALL read the pre-update value (no bypass).
REQ-027 Index SHALL wrap via truncation; PCs differing only above bit IDX_W+1 alias.

Reset
REQ-028 rst_n low SHALL asynchronously set all outputs to 0 and every counter to 01.
REQ-029 Reset released mid-operation SHALL discard any in-flight prediction; first valid output follows the first post-reset edge with Valid=1.

Configuration
REQ-030 With BP_GSHARE_EN defined, index SHALL be PC[IDX_W+1:2] XOR an IDX_W-bit global history register (GHR); GHR shifts in Upd_Taken on each Upd_Valid, resets to 0; update index uses Upd_PC XOR GHR value before the shift.
REQ-031 Without BP_GSHARE_EN, no GHR SHALL exist and indexing SHALL be per REQ-019.

Structure
REQ-032 Package branch_pkg SHALL hold opcode constants, the 2-bit counter encoding typedef, and the counter reset value.
REQ-033 Combinational decode and immediate generation SHALL be sub-module branch_decode; BHT and output registers stay in branch_predictor.

Verification
REQ-034 Reset, PC=0x100, Inst=32'h00728463 (beq) -> next edge Br_Dectected=1, Pred_Taken=0, Pred_Target=0x108.
REQ-035 Two Upd_Valid with Upd_PC=0x100, Upd_Taken=1, then re-present REQ-034 -> Pred_Taken=1; four not-taken updates -> counter 00, fifth keeps 00.
REQ-036 PC=0x20, Inst=32'hff5ff0ef (jal) -> Pred_Taken=1, Pred_Target=0x14; PC=0x40, Inst=32'hfe52fee3 (bgeu) -> Pred_Target=0x3C.
REQ-037 Inst=32'hf9c382e7 (jalr) -> Br_Dectected=1, Jalr_Dec=1, Pred_Target=0; Inst=32'h005282b3 (add) -> all outputs 0.
REQ-038 Stall=1 for 3 cycles with changing Inst -> outputs frozen; Flush=1 with Stall=1 -> outputs 0; same-cycle lookup/update at 0x100 -> old value seen.
